// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared types and constants for the ALU request arbiter
// Contents:
//   ctrl_state_t  controller FSM state encoding
//   ALU_OP_W      native opcode width of the shared ALU
//   alu_op_t      opcode type of the shared ALU
//   OPCNT_W       width of the saturating completed-operation counter
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } ctrl_state_t;

  localparam int ALU_OP_W = 2;
  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam int OPCNT_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant selection
// Ports:
//   req        in   NUM_REQ  request vector
//   ptr        in   IDX_W    highest-priority index for this decision
//   grant      out  NUM_REQ  one-hot grant (zero when no request)
//   grant_idx  out  IDX_W    encoded index of the granted requester
//   grant_any  out  1        some requester was granted
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  always_comb begin
    int         k;
    logic [IDX_W-1:0] kk;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    k         = 0;
    kk        = '0;
    // Scan starting at the pointer and wrapping; the first hit wins.
    for (int i = 0; i < NUM_REQ; i++) begin
      k  = (int'(ptr) + i) % NUM_REQ;
      kk = IDX_W'(k);
      if (!grant_any && req[kk]) begin
        grant[kk] = 1'b1;
        grant_idx = kk;
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_reg_arbiter.sv
// rtl/alu_reg_arbiter.sv - shares one ALU register among NUM_REQ requesters
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   req_valid/req_ready            per-requester command handshake
//   req_op/req_data                per-requester opcode and operand
//   rsp_valid/rsp_ready            per-requester response handshake
//   rsp_data/rsp_zero              shared captured result and zero flag
//   alu_data_in/alu_op/alu_load    drive to the shared ALU
//   alu_data_out/alu_zero_flag     result from the shared ALU
//   busy                           controller not idle
//   timeout_err                    sticky: a response was dropped
//   op_count                       saturating count of completed operations
module alu_reg_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = 4,
  parameter int OP_W        = 2,
  parameter int RSP_TIMEOUT = 15
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0][OP_W-1:0]     req_op,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]               rsp_valid,
  input  logic [NUM_REQ-1:0]               rsp_ready,
  output logic [DATA_W-1:0]                rsp_data,
  output logic                             rsp_zero,
  output logic [DATA_W-1:0]                alu_data_in,
  output logic [OP_W-1:0]                  alu_op,
  output logic                             alu_load,
  input  logic [DATA_W-1:0]                alu_data_out,
  input  logic                             alu_zero_flag,
  output logic                             busy,
  output logic                             timeout_err,
  output logic [OPCNT_W-1:0]               op_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMO_W = $clog2(RSP_TIMEOUT + 1);

  ctrl_state_t          state_q, state_d;
  logic [IDX_W-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [OP_W-1:0]      alu_op_q, alu_op_d;
  logic [DATA_W-1:0]    alu_data_q, alu_data_d;
  logic                 alu_load_q, alu_load_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 rsp_zero_q, rsp_zero_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [OPCNT_W-1:0]   op_count_q, op_count_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;
  logic [IDX_W-1:0]     ptr_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  // Pointer moves just past the requester that was served, win or drop.
  assign ptr_next = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    ptr_d         = ptr_q;
    alu_op_d      = alu_op_q;
    alu_data_d    = alu_data_q;
    alu_load_d    = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_valid_d   = rsp_valid_q;
    tmo_d         = tmo_q;
    timeout_err_d = timeout_err_q;
    op_count_d    = op_count_q;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt_d      = arb_idx;
          alu_op_d   = req_op[arb_idx];
          alu_data_d = req_data[arb_idx];
          // Registered so the load pulse covers exactly the ISSUE cycle.
          alu_load_d = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        rsp_data_d  = alu_data_out;
        rsp_zero_d  = alu_zero_flag;
        rsp_valid_d = NUM_REQ'(1) << gnt_q;
        tmo_d       = '0;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready[gnt_q]) begin
          rsp_valid_d = '0;
          ptr_d       = ptr_next;
          if (op_count_q != '1) begin
            op_count_d = op_count_q + 1'b1;
          end
          state_d = IDLE;
        end else if (tmo_q == TMO_W'(RSP_TIMEOUT - 1)) begin
          // Counter values 0..RSP_TIMEOUT-1 give RSP_TIMEOUT cycles of valid.
          rsp_valid_d   = '0;
          ptr_d         = ptr_next;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      ptr_q         <= '0;
      alu_op_q      <= '0;
      alu_data_q    <= '0;
      alu_load_q    <= 1'b0;
      rsp_data_q    <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_valid_q   <= '0;
      tmo_q         <= '0;
      timeout_err_q <= 1'b0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      ptr_q         <= ptr_d;
      alu_op_q      <= alu_op_d;
      alu_data_q    <= alu_data_d;
      alu_load_q    <= alu_load_d;
      rsp_data_q    <= rsp_data_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_valid_q   <= rsp_valid_d;
      tmo_q         <= tmo_d;
      timeout_err_q <= timeout_err_d;
      op_count_q    <= op_count_d;
    end
  end

  assign req_ready   = (state_q == IDLE) ? arb_grant : '0;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_zero    = rsp_zero_q;
  assign alu_data_in = alu_data_q;
  assign alu_op      = alu_op_q;
  assign alu_load    = alu_load_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = timeout_err_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_reg_arbiter.sv
// tb/tb_alu_reg_arbiter.sv - self-checking bench for alu_reg_arbiter
module tb_alu_reg_arbiter;

  localparam int NUM_REQ     = 2;
  localparam int DATA_W      = 4;
  localparam int OP_W        = 2;
  localparam int RSP_TIMEOUT = 15;

  logic                            clk = 1'b0;
  logic                            reset;
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ-1:0][OP_W-1:0]    req_op;
  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]              rsp_valid;
  logic [NUM_REQ-1:0]              rsp_ready;
  logic [DATA_W-1:0]               rsp_data;
  logic                            rsp_zero;
  logic [DATA_W-1:0]               alu_data_in;
  logic [OP_W-1:0]                 alu_op;
  logic                            alu_load;
  logic [DATA_W-1:0]               alu_data_out;
  logic                            alu_zero_flag;
  logic                            busy;
  logic                            timeout_err;
  logic [7:0]                      op_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          idx;
    logic [3:0]  data;
    logic        zero;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] ref_acc;
  logic [3:0] alu_acc;

  always #5 clk = ~clk;

  alu_reg_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .DATA_W      (DATA_W),
    .OP_W        (OP_W),
    .RSP_TIMEOUT (RSP_TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_data      (req_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_zero      (rsp_zero),
    .alu_data_in   (alu_data_in),
    .alu_op        (alu_op),
    .alu_load      (alu_load),
    .alu_data_out  (alu_data_out),
    .alu_zero_flag (alu_zero_flag),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .op_count      (op_count)
  );

  function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [1:0] op,
                                         input logic [3:0] d);
    case (op)
      2'b00:   return d;
      2'b01:   return a + d;
      2'b10:   return a - d;
      default: return a ^ d;
    endcase
  endfunction

  // Stand-in for the shared 4-bit ALU register.
  always @(posedge clk or posedge reset) begin
    if (reset) alu_acc <= '0;
    else if (alu_load) alu_acc <= alu_ref(alu_acc, alu_op, alu_data_in);
  end
  assign alu_data_out  = alu_acc;
  assign alu_zero_flag = (alu_acc == 4'd0);

  // Advance one cycle; any command accepted in this cycle gets its expected
  // result pushed from the reference accumulator.
  task automatic tick();
    logic [NUM_REQ-1:0] acc;
    exp_t e;
    #1;
    acc = req_valid & req_ready;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        ref_acc = alu_ref(ref_acc, req_op[i], req_data[i]);
        e.idx   = i;
        e.data  = ref_acc;
        e.zero  = (ref_acc == 4'd0);
        sb.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_op    = '0;
    req_data  = '0;
    sb.delete();
    ref_acc   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (rsp_valid != '0) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if ({req_ready, rsp_valid, rsp_data, rsp_zero, alu_data_in, alu_op, alu_load,
           busy, timeout_err, op_count} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: outputs rr=%b rv=%b rd=%h z=%b di=%h op=%h ld=%b busy=%b te=%b cnt=%0d, required all 0",
                 c, req_ready, rsp_valid, rsp_data, rsp_zero, alu_data_in, alu_op, alu_load,
                 busy, timeout_err, op_count);
      end
      tick();
    end
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    req_valid = 2'b01; req_op[0] = 2'b00; req_data[0] = 4'h5; rsp_ready = 2'b01;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL single_req_ready: got %b required 01", req_ready);
    end
    tick();
    req_valid = '0;
    n_checks++;
    if ({alu_load, alu_op, alu_data_in} !== {1'b1, 2'b00, 4'h5}) begin
      n_fail++;
      $display("FAIL single_issue: load=%b op=%h din=%h required 1/0/5", alu_load, alu_op, alu_data_in);
    end
    tick();
    n_checks++;
    if (alu_load !== 1'b0 || rsp_valid !== 2'b00 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_capture: load=%b rsp_valid=%b busy=%b required 0/00/1", alu_load, rsp_valid, busy);
    end
    tick();
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL single_sb: no accepted command, required 1");
    end else begin
      e = sb.pop_front();
      if (rsp_valid !== 2'b01 || rsp_data !== e.data || rsp_zero !== e.zero) begin
        n_fail++;
        $display("FAIL single_rsp: rv=%b data=%h zero=%b required 01/%h/%b",
                 rsp_valid, rsp_data, rsp_zero, e.data, e.zero);
      end
    end
    tick();
    n_checks++;
    if (rsp_valid !== 2'b00 || op_count !== 8'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: rv=%b cnt=%0d busy=%b required 00/1/0", rsp_valid, op_count, busy);
    end
  endtask

  task automatic test_alternate();
    exp_t e;
    int got;
    logic [1:0] exp_v;
    do_reset();
    req_op[0] = 2'b01; req_data[0] = 4'h3;
    req_op[1] = 2'b11; req_data[1] = 4'h6;
    req_valid = 2'b11; rsp_ready = 2'b11;
    got = 0;
    for (int c = 0; c < 80 && got < 4; c++) begin
      tick();
      if (rsp_valid != '0) begin
        exp_v = 2'b01 << (got % 2);
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL alt_sb: response %0d with nothing accepted", got);
        end else begin
          e = sb.pop_front();
          if (rsp_valid !== exp_v || e.idx != got % 2 || rsp_data !== e.data) begin
            n_fail++;
            $display("FAIL alt_rsp %0d: rv=%b idx=%0d data=%h required %b/%0d/%h",
                     got, rsp_valid, e.idx, rsp_data, exp_v, got % 2, e.data);
          end
        end
        got++;
        if (got == 4) req_valid = '0;
      end
    end
    n_checks++;
    if (got != 4) begin
      n_fail++; $display("FAIL alt_count: responses %0d required 4", got);
    end
    tick();
    n_checks++;
    if (op_count !== 8'd4 || busy !== 1'b0) begin
      n_fail++; $display("FAIL alt_op_count: cnt=%0d busy=%b required 4/0", op_count, busy);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    bit ok;
    int n;
    do_reset();
    req_valid = 2'b01; req_op[0] = 2'b00; req_data[0] = 4'h9; rsp_ready = 2'b00;
    tick();
    req_valid = '0;
    wait_rsp(ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL tmo_wait: no rsp_valid within 40 cycles");
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL tmo_sb: nothing accepted");
    end else begin
      e = sb.pop_front();
      if (rsp_data !== e.data || timeout_err !== 1'b0) begin
        n_fail++;
        $display("FAIL tmo_rsp: data=%h te=%b required %h/0", rsp_data, timeout_err, e.data);
      end
    end
    n = 0;
    while (rsp_valid[0] && n < 40) begin
      n++;
      tick();
    end
    n_checks++;
    if (n != RSP_TIMEOUT) begin
      n_fail++; $display("FAIL tmo_len: rsp_valid held %0d cycles required %0d", n, RSP_TIMEOUT);
    end
    n_checks++;
    if (timeout_err !== 1'b1 || op_count !== 8'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_state: te=%b cnt=%0d busy=%b required 1/0/0", timeout_err, op_count, busy);
    end
    req_valid = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_fail++; $display("FAIL tmo_next_grant: req_ready=%b required 10", req_ready);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_zero_hold();
    exp_t e;
    bit ok;
    do_reset();
    req_valid = 2'b01; req_op[0] = 2'b00; req_data[0] = 4'h0; rsp_ready = 2'b00;
    tick();
    req_valid = '0;
    wait_rsp(ok);
    n_checks++;
    if (!ok || sb.size() == 0) begin
      n_fail++; $display("FAIL zero_wait: ok=%0d sb=%0d required 1/1", ok, sb.size());
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (rsp_zero !== 1'b1 || rsp_data !== e.data) begin
      n_fail++; $display("FAIL zero_flag: zero=%b data=%h required 1/%h", rsp_zero, rsp_data, e.data);
    end
    for (int c = 0; c < 7; c++) begin
      // Last two cycles assert ready only on the non-granted index.
      rsp_ready = (c >= 5) ? 2'b10 : 2'b00;
      tick();
      n_checks++;
      if (rsp_valid !== 2'b01 || rsp_data !== e.data || rsp_zero !== e.zero) begin
        n_fail++;
        $display("FAIL zero_hold cycle %0d: rv=%b data=%h zero=%b required 01/%h/%b",
                 c, rsp_valid, rsp_data, rsp_zero, e.data, e.zero);
      end
    end
    rsp_ready = 2'b01;
    tick();
    n_checks++;
    if (rsp_valid !== 2'b00 || op_count !== 8'd1 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: rv=%b cnt=%0d te=%b required 00/1/0", rsp_valid, op_count, timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 2'b01; req_op[0] = 2'b00; req_data[0] = 4'hA; rsp_ready = 2'b01;
    tick();
    req_valid = '0;
    n_checks++;
    if (alu_load !== 1'b1) begin
      n_fail++; $display("FAIL mid_issue: alu_load=%b required 1", alu_load);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (alu_load !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_async: alu_load=%b busy=%b required 0/0", alu_load, busy);
    end
    sb.delete();
    ref_acc = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (rsp_valid !== 2'b00 || op_count !== 8'd0) begin
        n_fail++;
        $display("FAIL mid_after cycle %0d: rv=%b cnt=%0d required 00/0", c, rsp_valid, op_count);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = '0; rsp_ready = '0; req_op = '0; req_data = '0;
    ref_acc = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_alternate();
    test_timeout();
    test_zero_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
